sample_rate_gen: RTL and testbench

//  Downstream of the speed controller. Turns its 32-bit period word into a periodic

---
 rtl/sample_rate_gen.sv | 163 ++++++++++++++++
 tb/tb_sample_rate_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_rate_gen.sv
// Sample rate generator.
// Turns a 32-bit period word into a periodic one-cycle sample strobe, a
// level req/ack handshake toward the sample fetch logic, and a 50%-duty
// audio_clk that toggles once per sample. A new period is adopted only at
// a period boundary, so speed changes never produce a short or long sample.
// Optional feature macro: SAMPLE_RATE_STATS_EN adds a saturating 16-bit
// overrun event counter on port overrun_cnt.
module sample_rate_gen #(
    parameter logic [31:0] MIN_DIV     = 32'd16,
    parameter logic [31:0] DEFAULT_DIV = 32'd4544
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] divisor,
    input  logic        sample_ack,
    output logic        sample_tick,
    output logic        sample_req,
    output logic        audio_clk,
    output logic [31:0] div_active,
    output logic        overrun
`ifdef SAMPLE_RATE_STATS_EN
    ,
    output logic [15:0] overrun_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_active_q, div_active_d;
    logic        audio_clk_q, audio_clk_d;
    logic        req_q, req_d;
    logic        overrun_q, overrun_d;

    logic [31:0] eff_div;
    logic        last_cnt;
    logic        overrun_event;

    // Requests below the minimum period (including zero) are clamped up.
    assign eff_div  = (divisor < MIN_DIV) ? MIN_DIV : divisor;
    assign last_cnt = (cnt_q == (div_active_q - 32'd1));

    // State register.
    // NOTE: every clocked register uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enable alone moves between IDLE and RUN.
    // NOTE: each combinational output is given a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the strobe marks the last cycle of a period; it is
    // suppressed on the cycle enable drops so leaving RUN never ticks.
    always_comb begin
        sample_tick = 1'b0;
        if (state_q == RUN && enable && last_cnt) begin
            sample_tick = 1'b1;
        end
    end

    // Datapath next state: period counter, period reload, audio clock,
    // handshake and sticky overrun.
    always_comb begin
        cnt_d        = cnt_q;
        div_active_d = div_active_q;
        audio_clk_d  = audio_clk_q;
        req_d        = req_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (enable) begin
                    div_active_d = eff_div;
                end
            end
            RUN: begin
                if (!enable) begin
                    cnt_d = 32'd0;
                end else if (sample_tick) begin
                    cnt_d        = 32'd0;
                    div_active_d = eff_div;
                    audio_clk_d  = ~audio_clk_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: cnt_d = 32'd0;
        endcase

        // A tick always (re-)arms the request, so a tick coinciding with an
        // ack completes the old request and leaves a fresh one pending.
        if (sample_tick) begin
            req_d = 1'b1;
        end else if (req_q && sample_ack) begin
            req_d = 1'b0;
        end

        if (overrun_event) begin
            overrun_d = 1'b1;
        end
    end

    // A tick that finds the previous request still unserviced is an overrun.
    assign overrun_event = sample_tick && req_q && !sample_ack;

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= 32'd0;
            div_active_q <= DEFAULT_DIV;
            audio_clk_q  <= 1'b0;
            req_q        <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            audio_clk_q  <= audio_clk_d;
            req_q        <= req_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SAMPLE_RATE_STATS_EN
    logic [15:0] overrun_cnt_q;

    // Saturating count of overrun events.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_cnt_q <= 16'd0;
        end else if (overrun_event && overrun_cnt_q != 16'hFFFF) begin
            overrun_cnt_q <= overrun_cnt_q + 16'd1;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign sample_req = req_q;
    assign audio_clk  = audio_clk_q;
    assign div_active = div_active_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sample_rate_gen.sv
// Directed self-checking bench for sample_rate_gen (default parameters:
// MIN_DIV=16, DEFAULT_DIV=4544). Inputs change 2 time units after a rising
// edge; outputs are sampled on falling edges or 2 units after a rising edge.
`timescale 1ns/1ps
module tb_sample_rate_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] divisor;
    logic        sample_ack;
    logic        sample_tick;
    logic        sample_req;
    logic        audio_clk;
    logic [31:0] div_active;
    logic        overrun;
`ifdef SAMPLE_RATE_STATS_EN
    logic [15:0] overrun_cnt;
`endif

    sample_rate_gen dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .divisor     (divisor),
        .sample_ack  (sample_ack),
        .sample_tick (sample_tick),
        .sample_req  (sample_req),
        .audio_clk   (audio_clk),
        .div_active  (div_active),
        .overrun     (overrun)
`ifdef SAMPLE_RATE_STATS_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to timestamp ticks.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Auto-acknowledge: pulse ack for one cycle, two cycles after req rises.
    bit   auto_ack = 1'b0;
    logic ack_auto = 1'b0;
    logic ack_man  = 1'b0;
    int   req_age  = 0;
    always @(posedge clk) begin
        #2;
        if (sample_req === 1'b1) req_age = req_age + 1;
        else                     req_age = 0;
        ack_auto = auto_ack && (sample_req === 1'b1) && (req_age == 2);
    end
    assign sample_ack = ack_auto | ack_man;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Look for a tick on up to 'budget' falling edges; report its cycle stamp.
    task automatic wait_tick(input int budget, output int unsigned tick_cyc, output bit found);
        found    = 1'b0;
        tick_cyc = 0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (sample_tick === 1'b1) begin
                found    = 1'b1;
                tick_cyc = cyc;
            end
        end
    endtask

    int unsigned e, t1, t2, t3, t4, t5, t6, t7, t8, ta, tb;
    bit f;

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        divisor = 32'd4544;

        // Reset state
        step(3);
        check("rst_tick",    sample_tick, 0);
        check("rst_req",     sample_req,  0);
        check("rst_audio",   audio_clk,   0);
        check("rst_overrun", overrun,     0);
        check("rst_div",     div_active,  4544);
`ifdef SAMPLE_RATE_STATS_EN
        check("rst_ovcnt",   overrun_cnt, 0);
`endif
        reset = 1'b0;
        step(2);

        // 1: nominal rate with acks two cycles after each request
        auto_ack = 1'b1;
        enable   = 1'b1;
        e        = cyc;
        wait_tick(5000, t1, f);
        check("t1_found", f, 1);
        check("t1_first_latency", t1 - e, 4544);
        step(1);
        check("t1_audio_hi", audio_clk, 1);
        check("t1_req_raised", sample_req, 1);
        wait_tick(5000, t2, f);
        check("t1_period", t2 - t1, 4544);
        step(1);
        check("t1_audio_lo", audio_clk, 0);
        check("t1_overrun", overrun, 0);

        // 2: divisor change mid-period takes effect one period later
        step(100);
        divisor = 32'd4524;
        check("t2_div_hold", div_active, 4544);
        wait_tick(5000, t3, f);
        check("t2_old_period", t3 - t2, 4544);
        step(1);
        check("t2_div_new", div_active, 4524);
        wait_tick(5000, t4, f);
        check("t2_new_period", t4 - t3, 4524);

        // 3: divisor below minimum and zero clamp to 16
        step(1);
        check("t3_div_pre", div_active, 4524);
        divisor = 32'd3;
        wait_tick(5000, t5, f);
        check("t3_last_long", t5 - t4, 4524);
        step(1);
        check("t3_div_clamp3", div_active, 16);
        divisor = 32'd0;
        wait_tick(100, t6, f);
        check("t3_period3", t6 - t5, 16);
        wait_tick(100, t7, f);
        check("t3_period0", t7 - t6, 16);
        step(1);
        check("t3_div_clamp0", div_active, 16);
        check("t3_overrun", overrun, 0);

        // 5: ack exactly on a tick cycle while req=1
        step(3);
        auto_ack = 1'b0;
        check("t5_req_idle", sample_req, 0);
        wait_tick(100, t8, f);
        check("t5_period", t8 - t7, 16);
        step(16);
        check("t5_tick_now", sample_tick, 1);
        check("t5_req_before", sample_req, 1);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        check("t5_req_stays", sample_req, 1);
        check("t5_no_overrun", overrun, 0);

        // 6a: enable drop stops ticks; pending request still completes
        step(4);
        enable = 1'b0;
        wait_tick(40, ta, f);
        check("t6_no_tick_idle", f, 0);
        check("t6_req_survives", sample_req, 1);
        step(1);
        ack_man = 1'b1;
        step(1);
        ack_man = 1'b0;
        check("t6_req_done", sample_req, 0);
        check("t6_overrun", overrun, 0);

        // 6b: asynchronous reset mid-period
        divisor = 32'd20;
        enable  = 1'b1;
        e       = cyc;
        wait_tick(100, ta, f);
        check("t6_entry_latency", ta - e, 20);
        wait_tick(100, tb, f);
        check("t6_period20", tb - ta, 20);
        step(1);
        check("t6_pre_div", div_active, 20);
        check("t6_pre_audio", audio_clk, 1);
        check("t6_pre_overrun", overrun, 1);
        check("t6_pre_req", sample_req, 1);
        step(5);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_arst_req", sample_req, 0);
        check("t6_arst_audio", audio_clk, 0);
        check("t6_arst_overrun", overrun, 0);
        check("t6_arst_div", div_active, 4544);
        check("t6_arst_tick", sample_tick, 0);
        enable = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);

        // 4: ack never asserted -> overrun on second tick
        divisor = 32'd0;
        enable  = 1'b1;
        e       = cyc;
        wait_tick(100, ta, f);
        check("t4_entry_latency", ta - e, 16);
        step(1);
        check("t4_req1", sample_req, 1);
        check("t4_no_overrun1", overrun, 0);
        wait_tick(100, tb, f);
        check("t4_period", tb - ta, 16);
        step(1);
        check("t4_overrun2", overrun, 1);
        check("t4_req2", sample_req, 1);
`ifdef SAMPLE_RATE_STATS_EN
        check("t4_ovcnt1", overrun_cnt, 1);
`endif
        wait_tick(100, ta, f);
        check("t4_found3", f, 1);
        step(1);
        check("t4_overrun3", overrun, 1);
`ifdef SAMPLE_RATE_STATS_EN
        check("t4_ovcnt2", overrun_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
